// File: rtl/lsu_mem_initiator_pkg.sv
// lsu_pkg: shared funct3 codes, error causes and FSM state type for the load/store initiator
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_FUNCT3   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R} lsu_state_t;
endpackage

// File: rtl/lsu_mem_initiator_if.sv
// lsu_mem_initiator_if: word-addressed req/gnt/rvalid data-memory bus
interface lsu_mem_initiator_if #(parameter int ADDR_W = 6);
  logic req, we, gnt, rvalid;
  logic [ADDR_W-1:0] addr;
  logic [3:0] be;
  logic [31:0] wdata, rdata;
  modport master(output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave(input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_mem_initiator_lane_align.sv
// lsu_lane_align: funct3/alignment checks, byte enables, store lane shift and load extraction
module lsu_lane_align import lsu_pkg::*; (
  input  logic        wr,
  input  logic [2:0]  funct3,
  input  logic [1:0]  a,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] ld_val,
  output logic        misaligned,
  output logic        illegal
);
  logic [31:0] wmask, rsh;
  // funct3[1:0] encodes access size; funct3[2] selects zero extension for loads
  always_comb begin
    illegal = wr ? !(funct3 inside {F3_B, F3_H, F3_W}) : !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misaligned = (funct3[1:0] == 2'b01 && a[0]) || (funct3[1:0] == 2'b10 && a != 2'b00);
    be = funct3[1:0] == 2'b00 ? 4'b0001 << a : funct3[1:0] == 2'b01 ? 4'b0011 << a : 4'b1111;
    wmask = funct3[1:0] == 2'b00 ? {24'b0, wdata[7:0]} : funct3[1:0] == 2'b01 ? {16'b0, wdata[15:0]} : wdata;
    wdata_sh = wmask << {a, 3'b000};
    rsh = rdata >> {a, 3'b000};
    ld_val = funct3 == F3_B  ? {{24{rsh[7]}}, rsh[7:0]} :
             funct3 == F3_H  ? {{16{rsh[15]}}, rsh[15:0]} :
             funct3 == F3_BU ? {24'b0, rsh[7:0]} :
             funct3 == F3_HU ? {16'b0, rsh[15:0]} : rdata;
  end
endmodule

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: multi-cycle load/store owner of a handshaked word memory with timeout watchdog
module lsu_mem_initiator import lsu_pkg::*; #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic [1:0]  o_err_cause,
  lsu_mem_initiator_if.master mem
);
  lsu_state_t state;
  logic [7:0] cnt;
  logic [2:0] f3_q;
  logic [1:0] a_q;
  logic idle, expired, misaligned, illegal;
  logic [3:0] be;
  logic [31:0] wdata_sh, ld_val;
  logic unused_addr;
  assign idle = state == IDLE;
  assign o_busy = !idle;
  assign expired = cnt == 8'(TIMEOUT - 1);
  assign unused_addr = ^i_addr[31:ADDR_W+2];
  // Checks use the live command in IDLE; load extraction uses the latched command
  lsu_lane_align u_align (
    .wr(idle ? i_wr : mem.we),
    .funct3(idle ? i_funct3 : f3_q),
    .a(idle ? i_addr[1:0] : a_q),
    .wdata(i_wdata),
    .rdata(mem.rdata),
    .be(be),
    .wdata_sh(wdata_sh),
    .ld_val(ld_val),
    .misaligned(misaligned),
    .illegal(illegal)
  );
  // Command acceptance, memory handshake and watchdog; completion beats a same-edge timeout
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      f3_q <= '0;
      a_q <= '0;
      o_done <= 1'b0;
      o_err <= 1'b0;
      o_rdata <= '0;
      o_err_cause <= '0;
      mem.req <= 1'b0;
      mem.we <= 1'b0;
      mem.addr <= '0;
      mem.be <= '0;
      mem.wdata <= '0;
    end else begin
      o_done <= 1'b0;
      o_err <= 1'b0;
      case (state)
        IDLE: if (i_req) begin
          if (illegal || misaligned) begin
            o_err <= 1'b1;
            o_err_cause <= illegal ? ERR_FUNCT3 : ERR_MISALIGN;
          end else begin
            state <= ISSUE;
            cnt <= '0;
            f3_q <= i_funct3;
            a_q <= i_addr[1:0];
            mem.req <= 1'b1;
            mem.we <= i_wr;
            mem.addr <= i_addr[ADDR_W+1:2];
            mem.be <= be;
            mem.wdata <= wdata_sh;
          end
        end
        ISSUE, WAIT_R: begin
          cnt <= cnt + 8'd1;
          if (state == ISSUE && mem.gnt) begin
            mem.req <= 1'b0;
            o_done <= mem.we;
            state <= mem.we ? IDLE : WAIT_R;
          end else if (state == WAIT_R && mem.rvalid) begin
            o_rdata <= ld_val;
            o_done <= 1'b1;
            state <= IDLE;
          end else if (expired) begin
            mem.req <= 1'b0;
            o_err <= 1'b1;
            o_err_cause <= ERR_TIMEOUT;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb_lsu_mem_initiator: directed and randomized load/store transactions checked against a behavioural model
module tb_lsu_mem_initiator;
  localparam int T = 16;
  logic clk = 1'b0, rst = 1'b0, req = 1'b0, wr = 1'b0;
  logic [2:0] funct3 = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic busy, done, err;
  logic [31:0] rdata;
  logic [1:0] err_cause;
  logic [31:0] last_rdata = '0;
  logic [1:0] last_cause = '0;
  int n_checks = 0, n_fail = 0;

  lsu_mem_initiator_if #(.ADDR_W(6)) mem();

  lsu_mem_initiator #(.ADDR_W(6), .TIMEOUT(T)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_wr(wr), .i_funct3(funct3),
    .i_addr(addr), .i_wdata(wdata), .o_busy(busy), .o_done(done),
    .o_rdata(rdata), .o_err(err), .o_err_cause(err_cause), .mem(mem)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit legal(input logic w, input logic [2:0] f3);
    return w ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
  endfunction

  function automatic logic [3:0] be_ref(input int a, input int n);
    logic [3:0] b = '0;
    for (int i = 0; i < 4; i++) b[i] = (i >= a && i < a + n);
    return b;
  endfunction

  function automatic logic [31:0] wd_ref(input logic [31:0] d, input int a, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) if (i >= a && i < a + n) r[8*i +: 8] = d[8*(i-a) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ld_ref(input logic [2:0] f3, input int a, input logic [31:0] d);
    longint v = longint'(d >> (8 * a));
    int n = nbytes(f3);
    if (n == 4) return d;
    v = v % (longint'(1) << (8 * n));
    if (!f3[2] && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return 32'(v);
  endfunction

  // gd: busy cycle in which gnt is driven; rd: cycles after gnt until rvalid (<=0 means never)
  task automatic run_cmd(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                         input int gd, input int rd, input logic [31:0] mrd);
    int lane = int'(a[1:0]);
    int n = nbytes(f3);
    bit ok = legal(w, f3);
    bit mis = ok && (lane % n != 0);
    int k = 0;
    int r = gd + rd;
    int eb;
    bit fin;
    req = 1'b1; wr = w; funct3 = f3; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    if (!ok || mis) begin
      last_cause = !ok ? 2'b10 : 2'b01;
      check("err_pulse", {busy, done, err, mem.req}, 4'b0010);
      check("err_cause", err_cause, last_cause);
      check("err_rdata_held", rdata, last_rdata);
      return;
    end
    fin = w ? (gd <= T - 1) : (gd <= T - 1 && rd > 0 && r <= T - 1);
    eb = !fin ? T : w ? gd + 1 : r + 1;
    while (busy && k < 40) begin
      if (k <= gd) begin
        check("mem_req", mem.req, 1'b1);
        check("mem_addr", mem.addr, a[7:2]);
        check("mem_be", mem.be, be_ref(lane, n));
        check("mem_we", mem.we, w);
        if (w) check("mem_wdata", mem.wdata, wd_ref(d, lane, n));
      end else check("mem_req_drop", mem.req, 1'b0);
      check("no_pulse_busy", {done, err}, 2'b00);
      mem.gnt = (k == gd);
      mem.rvalid = (rd > 0 && k == r) || (k < gd && $urandom_range(0, 3) == 0);
      mem.rdata = (rd > 0 && k == r) ? mrd : $urandom;
      @(posedge clk); #1;
      mem.gnt = 1'b0;
      mem.rvalid = 1'b0;
      k++;
    end
    check("busy_cycles", k, eb);
    if (fin && !w) last_rdata = ld_ref(f3, lane, mrd);
    if (!fin) last_cause = 2'b11;
    check("end_pulse", {done, err}, fin ? 2'b10 : 2'b01);
    check("end_cause", err_cause, last_cause);
    check("end_rdata", rdata, last_rdata);
    check("end_req", mem.req, 1'b0);
    if (!fin) begin
      mem.gnt = 1'b1;
      mem.rvalid = 1'b1;
      mem.rdata = $urandom;
      @(posedge clk); #1;
      mem.gnt = 1'b0;
      mem.rvalid = 1'b0;
      check("late_ignored", {busy, done, err, mem.req}, 4'b0000);
      check("late_rdata", rdata, last_rdata);
    end
  endtask

  initial begin
    logic w;
    logic [2:0] f3;
    logic [31:0] a, d, mrd;
    int gd, rd;
    mem.gnt = 1'b0;
    mem.rvalid = 1'b0;
    mem.rdata = '0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("reset_ctrl", {busy, done, err, err_cause, mem.req, mem.we, mem.be}, 0);
    check("reset_rdata", rdata, 0);
    check("reset_addr", mem.addr, 0);
    check("reset_wdata", mem.wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_cmd(1'b1, 3'b010, 32'h38, 32'hDEADBEEF, 3, 0, 0);
    run_cmd(1'b1, 3'b000, 32'h3B, 32'h000000F0, 1, 0, 0);
    run_cmd(1'b0, 3'b000, 32'h3B, 32'h0, 0, 1, 32'hF0123456);
    run_cmd(1'b0, 3'b100, 32'h3B, 32'h0, 1, 2, 32'hF0123456);
    run_cmd(1'b0, 3'b001, 32'h02, 32'h0, 0, 1, 32'h80017FFF);
    run_cmd(1'b0, 3'b101, 32'h02, 32'h0, 2, 1, 32'h80017FFF);
    run_cmd(1'b0, 3'b010, 32'h06, 32'h0, 0, 1, 32'h1);
    run_cmd(1'b0, 3'b011, 32'h00, 32'h0, 0, 1, 32'h1);
    run_cmd(1'b1, 3'b101, 32'h01, 32'h1234, 0, 0, 0);
    run_cmd(1'b0, 3'b010, 32'h40, 32'h0, 2, 0, 0);
    run_cmd(1'b0, 3'b010, 32'h00, 32'h0, 2, 13, 32'h12345678);
    run_cmd(1'b1, 3'b001, 32'h06, 32'hABCD, T - 1, 0, 0);
    run_cmd(1'b1, 3'b010, 32'h08, 32'h1, T, 0, 0);
    run_cmd(1'b0, 3'b010, 32'h0C, 32'h0, 0, T, 32'h55AA55AA);
    // asynchronous reset while waiting for read data
    req = 1'b1; wr = 1'b0; funct3 = 3'b010; addr = 32'h10;
    @(posedge clk); #1;
    req = 1'b0;
    mem.gnt = 1'b1;
    @(posedge clk); #1;
    mem.gnt = 1'b0;
    check("pre_rst_busy", busy, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("rst_ctrl", {busy, done, err, err_cause, mem.req, mem.we, mem.be}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr", mem.addr, 0);
    check("rst_wdata", mem.wdata, 0);
    mem.rvalid = 1'b1;
    mem.rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    check("rst_hold", {busy, done, err}, 3'b000);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    mem.rvalid = 1'b0;
    check("post_rst", {busy, done, err, mem.req}, 4'b0000);
    @(posedge clk); #1;
    check("post_rst2", {busy, done, err, err_cause}, 5'b00000);
    check("post_rst_rdata", rdata, 0);
    last_rdata = '0;
    last_cause = '0;
    run_cmd(1'b1, 3'b010, 32'h38, 32'h0BADF00D, 1, 0, 0);
    for (int i = 0; i < 150; i++) begin
      w = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      d = $urandom;
      mrd = $urandom;
      gd = $urandom_range(0, 3) == 0 ? $urandom_range(0, 18) : $urandom_range(0, 3);
      rd = $urandom_range(0, 7) == 0 ? 0 : ($urandom_range(0, 3) == 0 ? $urandom_range(1, 16) : $urandom_range(1, 3));
      run_cmd(w, f3, a, d, gd, rd, mrd);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
